// File: rtl/axi_byte_prefetch_if.sv
// Bus bundle for the byte prefetcher: AXI4-Lite-style read channels toward memory
// and the byte stream toward the channel core.
interface axi_byte_prefetch_if;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;

    modport master (
        output m_axi_araddr, m_axi_arvalid, m_axi_rready, m_axis_tdata, m_axis_tvalid,
        input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid, m_axis_tready
    );

    modport slave (
        input  m_axi_araddr, m_axi_arvalid, m_axi_rready, m_axis_tdata, m_axis_tvalid,
        output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid, m_axis_tready
    );
endinterface

// File: rtl/axi_byte_prefetch.sv
// Fetches aligned 64-bit words from memory and unpacks the requested byte range
// into a byte FIFO that feeds the channel's data stream.
module axi_byte_prefetch #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                       aclk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [31:0]                addr,
    input  logic [15:0]                count,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    axi_byte_prefetch_if.master        bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_R, S_UNPACK, S_DRAIN, S_ABORT
    } state_t;

    state_t        state_reg, state_next;
    logic [31:0]   fetch_addr_reg, fetch_addr_next;
    logic [2:0]    lane_reg, lane_next;
    logic [15:0]   remaining_reg, remaining_next;
    logic [63:0]   word_reg, word_next;
    logic          error_reg, error_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          arvalid, rready, push, flush;
    logic [7:0]    push_data;
    logic [7:0]    word_bytes [8];

    // FIFO: storage array plus a registered head byte that drives the stream
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]   fill_reg;
    logic [7:0]       tdata_reg;
    logic             tvalid_reg;
    logic             pop, head_load, mem_empty, mem_write, fifo_room;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign word_bytes[gi] = word_reg[8*gi +: 8];
        end
    endgenerate

    assign push_data = word_bytes[lane_reg];
    assign pop       = tvalid_reg && bus.m_axis_tready;
    assign head_load = !tvalid_reg || pop;
    assign mem_empty = (fill_reg - (PTR_W+1)'(tvalid_reg)) == '0;
    // An empty store with a free head slot lets the new byte go straight to the head
    assign mem_write = push && !(head_load && mem_empty);
    assign fifo_room = fill_reg <= (PTR_W+1)'(FIFO_DEPTH - 8);

    always_ff @(posedge aclk) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
            tvalid_reg <= 1'b0;
            tdata_reg  <= '0;
        end else begin
            fill_reg <= fill_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            if (mem_write)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (head_load) begin
                if (!mem_empty) begin
                    tdata_reg  <= fifo_mem[rd_ptr_reg];
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    tvalid_reg <= 1'b1;
                end else if (push) begin
                    tdata_reg  <= push_data;
                    tvalid_reg <= 1'b1;
                end else begin
                    tvalid_reg <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (mem_write)
            fifo_mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            fetch_addr_reg <= '0;
            lane_reg       <= '0;
            remaining_reg  <= '0;
            word_reg       <= '0;
            error_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            fetch_addr_reg <= fetch_addr_next;
            lane_reg       <= lane_next;
            remaining_reg  <= remaining_next;
            word_reg       <= word_next;
            error_reg      <= error_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        fetch_addr_next = fetch_addr_reg;
        lane_next       = lane_reg;
        remaining_next  = remaining_reg;
        word_next       = word_reg;
        error_next      = error_reg;
        busy_next       = busy_reg;
        done_next       = 1'b0;
        arvalid         = 1'b0;
        rready          = 1'b0;
        push            = 1'b0;
        flush           = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    error_next      = 1'b0;
                    fetch_addr_next = {addr[31:3], 3'b000};
                    lane_next       = addr[2:0];
                    remaining_next  = count;
                    if (count == 16'd0) begin
                        done_next = 1'b1;
                    end else begin
                        busy_next  = 1'b1;
                        state_next = S_AR;
                    end
                end
            end
            S_AR: begin
                // Only ask for a word once the FIFO can absorb all eight of its bytes
                if (fifo_room) begin
                    arvalid = 1'b1;
                    if (bus.m_axi_arready)
                        state_next = S_R;
                end
            end
            S_R: begin
                rready = 1'b1;
                if (bus.m_axi_rvalid) begin
                    if (bus.m_axi_rresp != 2'b00) begin
                        error_next = 1'b1;
                        state_next = S_ABORT;
                    end else begin
                        word_next  = bus.m_axi_rdata;
                        state_next = S_UNPACK;
                    end
                end
            end
            S_UNPACK: begin
                push           = 1'b1;
                lane_next      = lane_reg + 3'd1;
                remaining_next = remaining_reg - 16'd1;
                if (lane_reg == 3'd7 || remaining_reg == 16'd1) begin
                    if (remaining_reg != 16'd1) begin
                        fetch_addr_next = fetch_addr_reg + 32'd8;
                        lane_next       = 3'd0;
                        state_next      = S_AR;
                    end else begin
                        state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (fill_reg == '0) begin
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = S_IDLE;
                end
            end
            S_ABORT: begin
                flush      = 1'b1;
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign busy              = busy_reg;
    assign done              = done_reg;
    assign error             = error_reg;
    assign bus.m_axi_araddr  = fetch_addr_reg;
    assign bus.m_axi_arvalid = arvalid;
    assign bus.m_axi_rready  = rready;
    assign bus.m_axis_tdata  = tdata_reg;
    assign bus.m_axis_tvalid = tvalid_reg;
endmodule

// File: tb/tb_axi_byte_prefetch.sv
// Randomized bench for axi_byte_prefetch: memory responder, stream sink and a
// transfer-level reference model of expected addresses and bytes.
module tb_axi_byte_prefetch;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] addr = '0;
    logic [15:0] count = '0;
    logic        busy, done, error;

    axi_byte_prefetch_if ifc();

    axi_byte_prefetch #(.FIFO_DEPTH(DEPTH)) dut (
        .aclk  (clk),
        .reset (reset),
        .start (start),
        .addr  (addr),
        .count (count),
        .busy  (busy),
        .done  (done),
        .error (error),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // reference model state for the current transfer
    logic [31:0] cur_addr = '0;
    int          cur_cnt = 0, err_beat = -1, beat_idx = 0;
    int          pushed = 0, popped = 0, ar_extra = 0, byte_extra = 0;
    int          done_cnt = 0, done_base = 0, arvalid_cycles = 0, av_base = 0, r_beats = 0;
    int          tready_mode = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] ar_exp[$];

    // responder / sink state
    bit          pending = 0, ar_hs = 0, r_hs = 0, prev_stall = 0;
    logic [31:0] pend_addr = '0;
    int          rdelay = 0;
    logic [7:0]  prev_data = '0;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return a[7:0] ^ (a[15:8] - 8'h10) ^ a[23:16] ^ a[31:24];
    endfunction

    // bytes of the requested range that fall into the j-th fetched word
    function automatic int beat_bytes(input int j);
        int off0 = int'(cur_addr[2:0]);
        int first, n;
        first = (j == 0) ? 0 : (8 - off0) + 8 * (j - 1);
        n = (j == 0) ? 8 - off0 : 8;
        if (cur_cnt - first < n) n = cur_cnt - first;
        return n;
    endfunction

    initial begin
        ifc.m_axi_arready = 1'b0;
        ifc.m_axi_rvalid  = 1'b0;
        ifc.m_axi_rdata   = '0;
        ifc.m_axi_rresp   = 2'b00;
        ifc.m_axis_tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                ifc.m_axi_rvalid = 1'b0;
                pending = 0; ar_hs = 0; r_hs = 0; prev_stall = 0;
                continue;
            end
            if (r_hs) ifc.m_axi_rvalid = 1'b0;
            if (ar_hs) begin
                pending = 1;
                rdelay = $urandom_range(0, 3);
            end
            if (pending && !ifc.m_axi_rvalid) begin
                if (rdelay == 0) begin
                    for (int k = 0; k < 8; k++)
                        ifc.m_axi_rdata[8*k +: 8] = mem_byte(pend_addr + 32'(k));
                    ifc.m_axi_rresp  = (beat_idx == err_beat) ? 2'b10 : 2'b00;
                    ifc.m_axi_rvalid = 1'b1;
                    pending = 0;
                end else begin
                    rdelay--;
                end
            end
            ifc.m_axi_arready = ($urandom_range(0, 3) != 0);
            case (tready_mode)
                0:       ifc.m_axis_tready = 1'b0;
                1:       ifc.m_axis_tready = 1'b1;
                default: ifc.m_axis_tready = ($urandom_range(0, 1) != 0);
            endcase

            if (ifc.m_axi_arvalid) arvalid_cycles++;
            ar_hs = ifc.m_axi_arvalid && ifc.m_axi_arready;
            if (ar_hs) begin
                check_value("ar_outstanding", 64'(pending || ifc.m_axi_rvalid), 64'd0);
                check_value("ar_fifo_room", 64'((pushed - popped) <= DEPTH - 8), 64'd1);
                if (ar_exp.size() > 0) check_value("araddr", 64'(ifc.m_axi_araddr), 64'(ar_exp.pop_front()));
                else ar_extra++;
                pend_addr = ifc.m_axi_araddr;
            end
            r_hs = ifc.m_axi_rvalid && ifc.m_axi_rready;
            if (r_hs) begin
                pushed += beat_bytes(beat_idx);
                beat_idx++;
                r_beats++;
            end
            if (prev_stall && ifc.m_axis_tvalid)
                check_value("tdata_hold", 64'(ifc.m_axis_tdata), 64'(prev_data));
            prev_stall = ifc.m_axis_tvalid && !ifc.m_axis_tready;
            prev_data  = ifc.m_axis_tdata;
            if (ifc.m_axis_tvalid && ifc.m_axis_tready) begin
                popped++;
                if (exp_q.size() > 0) check_value("tdata", 64'(ifc.m_axis_tdata), 64'(exp_q.pop_front()));
                else byte_extra++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic start_xfer(input logic [31:0] a, input int c, input int mode, input int eb);
        int nbeats, nar;
        cur_addr = a; cur_cnt = c; err_beat = eb; beat_idx = 0;
        pushed = 0; popped = 0; ar_extra = 0; byte_extra = 0;
        exp_q.delete(); ar_exp.delete();
        nbeats = (c == 0) ? 0 : (int'(a[2:0]) + c + 7) / 8;
        nar = (eb >= 0 && eb < nbeats) ? eb + 1 : nbeats;
        for (int j = 0; j < nar; j++) ar_exp.push_back({a[31:3], 3'b000} + 32'(8 * j));
        if (eb < 0) for (int i = 0; i < c; i++) exp_q.push_back(mem_byte(a + 32'(i)));
        tready_mode = mode;
        done_base = done_cnt;
        av_base = arvalid_cycles;
        start = 1'b1; addr = a; count = 16'(c);
        @(posedge clk); #1;
        start = 1'b0;
        check_value("start_busy", 64'(busy), 64'(c != 0));
        check_value("start_err_clr", 64'(error), 64'd0);
        if (c == 0) check_value("zero_done_lat", 64'(done), 64'd1);
        else check_value("arvalid_lat", 64'(ifc.m_axi_arvalid), 64'd1);
        #1;
    endtask

    task automatic end_xfer(input bit exp_err);
        int n = 0;
        while (done_cnt == done_base && n < 3000) begin @(posedge clk); #2; n++; end
        check_value("done_seen", 64'(done_cnt - done_base), 64'd1);
        tick(1);
        check_value("done_pulse", 64'(done), 64'd0);
        check_value("busy_end", 64'(busy), 64'd0);
        check_value("error_end", 64'(error), 64'(exp_err));
        check_value("tvalid_end", 64'(ifc.m_axis_tvalid), 64'd0);
        tick(5);
        check_value("bytes_left", 64'(exp_q.size()), 64'd0);
        check_value("ar_left", 64'(ar_exp.size()), 64'd0);
        check_value("ar_extra", 64'(ar_extra), 64'd0);
        check_value("byte_extra", 64'(byte_extra), 64'd0);
        check_value("done_once", 64'(done_cnt - done_base), 64'd1);
        if (cur_cnt == 0) check_value("zero_no_ar", 64'(arvalid_cycles - av_base), 64'd0);
        $display("xfer addr=0x%08h count=%0d err_beat=%0d popped=%0d checks=%0d", cur_addr, cur_cnt, err_beat, popped, n_checks);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value(tag, 64'({busy, done, error, ifc.m_axis_tvalid, ifc.m_axi_arvalid, ifc.m_axi_rready}), 64'd0);
        check_value({tag, "_araddr"}, 64'(ifc.m_axi_araddr), 64'd0);
    endtask

    initial begin
        int rb, db, n;
        reset = 1'b1;
        tick(3);
        check_reset_outputs("reset_outs");
        reset = 1'b0;
        tick(2);

        start_xfer(32'h0000_1000, 16, 1, -1); end_xfer(1'b0);
        start_xfer(32'h0000_1005, 5, 1, -1);  end_xfer(1'b0);
        start_xfer(32'h0000_1234, 0, 1, -1);  end_xfer(1'b0);

        // FIFO throttling of the third fetch while the sink is stalled
        start_xfer(32'h0000_2000, 24, 0, -1);
        tick(60);
        check_value("throttle_ar", 64'(ar_exp.size()), 64'd1);
        check_value("throttle_tvalid", 64'(ifc.m_axis_tvalid), 64'd1);
        tready_mode = 1;
        end_xfer(1'b0);

        // error response on the second beat, then a clean transfer clears error
        start_xfer(32'h0000_3003, 20, 0, 1); end_xfer(1'b1);
        start_xfer(32'h0000_1000, 16, 1, -1); end_xfer(1'b0);

        // start while busy is ignored
        start_xfer(32'h0000_5000, 16, 0, -1);
        tick(30);
        check_value("busy_two_ar", 64'(ar_exp.size()), 64'd0);
        start = 1'b1; addr = 32'h0000_6000; count = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        check_value("busy_ignore", 64'(busy), 64'd1);
        #1;
        tick(3);
        check_value("busy_hold", 64'(busy), 64'd1);
        tready_mode = 1;
        end_xfer(1'b0);

        // reset while unpacking abandons the transfer silently
        rb = r_beats;
        start_xfer(32'h0000_4000, 16, 0, -1);
        n = 0;
        while (r_beats == rb && n < 200) begin tick(1); n++; end
        check_value("first_beat_seen", 64'(r_beats - rb), 64'd1);
        tick(1);
        reset = 1'b1;
        db = done_cnt;
        @(posedge clk); #1;
        check_reset_outputs("mid_reset_outs");
        #1;
        tick(1);
        reset = 1'b0;
        exp_q.delete(); ar_exp.delete();
        av_base = arvalid_cycles;
        tick(20);
        check_reset_outputs("post_reset_outs");
        check_value("post_reset_no_done", 64'(done_cnt - db), 64'd0);
        check_value("post_reset_no_ar", 64'(arvalid_cycles - av_base), 64'd0);

        // address wrap and randomized traffic
        start_xfer(32'hFFFF_FFFA, 12, 1, -1); end_xfer(1'b0);
        for (int t = 0; t < 20; t++) begin
            start_xfer($urandom(), $urandom_range(0, 40), 2, -1);
            end_xfer(1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
